// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device using the open-drain host request
// protocol: inhibit the clock, assert the start bit, then shift the frame on
// device clock falls and check the ACK. The lines are driven through external
// open-drain buffers, so a 1 on either *_oe_o output pulls that line low.
// Optional build macro: PS2_TX_GLITCH_FILTER_EN adds a stability filter on the
// sensed clock line before fall detection.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_done_o,
    output logic       tx_err_o,
    input  logic       ps2_clk_in_i,
    input  logic       ps2_data_in_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    // One counter serves both the inhibit interval and the fall timeout.
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;      // number of device clock falls seen in the frame
    logic [8:0]    shreg_q, shreg_d;  // {parity, data}, shifted out LSB first
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic clk_prev_q;
    logic clk_flt;
    logic clk_fall;

    // Two-flop synchronizers for the asynchronous line senses; idle level is 1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_in_i;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic [FW-1:0] filt_cnt_q;
    logic          filt_clk_q;

    // Filtered clock follows the synced clock only after FILTER_LEN stable samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_cnt_q <= '0;
            filt_clk_q <= 1'b1;
        end else if (clk_s2_q == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q >= FW'(FILTER_LEN - 1)) begin
            filt_cnt_q <= '0;
            filt_clk_q <= clk_s2_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    assign clk_flt = filt_clk_q;
`else
    assign clk_flt = clk_s2_q;
`endif

    // Previous clock sample for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_flt;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_flt;

    // State, counters and registered line enables.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: line enables are computed one cycle ahead so the
    // open-drain controls come straight from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid_i) begin
                    shreg_d   = {~^tx_data_i, tx_data_i};
                    bit_d     = '0;
                    cnt_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES <= 1);
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (cnt_q >= INH_LAST) begin
                    // Release the clock, keep the start bit on the data line.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_XFER;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    data_oe_d = (cnt_d == INH_LAST);
                end
            end

            ST_XFER: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (bit_q != 4'd11) begin
                        bit_d = bit_q + 4'd1;
                    end
                    if (bit_q <= 4'd8) begin
                        // Falls 1..9: eight data bits then parity.
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[8:1]};
                    end else if (bit_q == 4'd9) begin
                        // Fall 10: stop bit, line released.
                        data_oe_d = 1'b0;
                    end else begin
                        // Fall 11: device must hold data low as ACK.
                        data_oe_d = 1'b0;
                        clk_oe_d  = 1'b0;
                        state_d   = dat_s2_q ? ST_ERROR : ST_WAIT_IDLE;
                    end
                end else if (cnt_q >= TMO_LIM) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q >= TMO_LIM) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_ERROR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign tx_ready_o    = (state_q == ST_IDLE);
    assign tx_err_o      = (state_q == ST_ERROR);
    assign tx_done_o     = done_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule
